// File: rtl/lm32_trace_buffer_if.sv
// lm32_trace_buffer_if: request/valid drain port between the trace buffer
// (slave) and a debug host (master).
interface lm32_trace_buffer_if;
    logic        rd_req_i;
    logic        rd_valid_o;
    logic [29:0] rd_pc_o;
    logic [31:0] rd_inst_o;
    logic [15:0] rd_stamp_o;

    modport master (
        output rd_req_i,
        input  rd_valid_o, rd_pc_o, rd_inst_o, rd_stamp_o
    );

    modport slave (
        input  rd_req_i,
        output rd_valid_o, rd_pc_o, rd_inst_o, rd_stamp_o
    );
endinterface

// File: rtl/lm32_trace_buffer.sv
// lm32_trace_buffer: LM32 retired-instruction trace capture with arm/trigger/freeze
// control and a request/valid drain port. Optional macro: LM32_TRACE_CYCLE_STAMP_EN.
module lm32_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_x,
    input  logic                   stall_m,
    input  logic                   valid_w,
    input  logic                   kill_w,
    input  logic [31:0]            instruction_d,
    input  logic [29:0]            pc_w,
    input  logic                   arm_i,
    input  logic                   trig_i,
    input  logic                   clear_i,
    lm32_trace_buffer_if.slave     rd,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   wrapped_o,
    output logic [1:0]             state_o
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [7:0]  POST_CNT   = 8'(POST_TRIG);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_POST   = 2'b10,
        S_FROZEN = 2'b11
    } state_t;

    state_t        r_state;
    logic [31:0]   r_inst_x;
    logic [31:0]   r_inst_m;
    logic [31:0]   r_inst_w;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_wrapped;
    logic [7:0]    r_post_cnt;
    logic          r_rd_valid;
    logic [29:0]   r_rd_pc;
    logic [31:0]   r_rd_inst;
    logic [29:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_inst [DEPTH];

    logic w_commit;
    logic w_capture;
    logic w_pop;
    logic w_full;

    assign w_commit  = valid_w & ~kill_w;
    assign w_capture = w_commit & ((r_state == S_RUN) | (r_state == S_POST)) & ~clear_i & ~rst_i;
    assign w_pop     = (r_state == S_FROZEN) & rd.rd_req_i & (r_level != '0) & ~clear_i & ~rst_i;
    assign w_full    = (r_level == LEVEL_FULL);

    // Re-create the D->X->M->W instruction shift so the word pairs with pc_w.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inst_x <= '0;
            r_inst_m <= '0;
            r_inst_w <= '0;
        end else begin
            if (!stall_x) r_inst_x <= instruction_d;
            if (!stall_m) r_inst_m <= r_inst_x;
            r_inst_w <= r_inst_m;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and level decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_capture) begin
            r_mem_pc[r_wr_ptr]   <= pc_w;
            r_mem_inst[r_wr_ptr] <= r_inst_w;
        end
    end

`ifdef LM32_TRACE_CYCLE_STAMP_EN
    logic [15:0] r_delta;
    logic [15:0] r_rd_stamp;
    logic [15:0] w_delta_inc;
    logic [15:0] r_mem_stamp [DEPTH];

    // The stored stamp counts the capture cycle itself, i.e. cycles since the previous capture/arm.
    assign w_delta_inc = (r_delta == 16'hFFFF) ? r_delta : r_delta + 16'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_delta <= '0;
        end else if (w_capture || (r_state == S_IDLE && arm_i)) begin
            r_delta <= '0;
        end else begin
            r_delta <= w_delta_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_capture) r_mem_stamp[r_wr_ptr] <= w_delta_inc;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_stamp <= '0;
        end else if (w_pop) begin
            r_rd_stamp <= r_mem_stamp[r_rd_ptr];
        end
    end

    assign rd.rd_stamp_o = r_rd_stamp;
`else
    assign rd.rd_stamp_o = 16'd0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_wrapped  <= 1'b0;
            r_post_cnt <= '0;
            r_rd_valid <= 1'b0;
            r_rd_pc    <= '0;
            r_rd_inst  <= '0;
        end else if (clear_i) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_wrapped  <= 1'b0;
            r_post_cnt <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_pc   <= r_mem_pc[r_rd_ptr];
                r_rd_inst <= r_mem_inst[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_level   <= r_level - (AW+1)'(1);
            end
            // A full buffer drops its oldest entry to make room.
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_full) begin
                    r_rd_ptr  <= r_rd_ptr + AW'(1);
                    r_wrapped <= 1'b1;
                end else begin
                    r_level <= r_level + (AW+1)'(1);
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (arm_i) begin
                        r_state    <= S_RUN;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_level    <= '0;
                        r_wrapped  <= 1'b0;
                        r_post_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (trig_i) begin
                        if (POST_TRIG == 0) begin
                            r_state <= S_FROZEN;
                        end else begin
                            r_state    <= S_POST;
                            r_post_cnt <= POST_CNT;
                        end
                    end
                end
                S_POST: begin
                    if (w_capture) begin
                        r_post_cnt <= r_post_cnt - 8'd1;
                        if (r_post_cnt == 8'd1) r_state <= S_FROZEN;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign rd.rd_valid_o = r_rd_valid;
    assign rd.rd_pc_o    = r_rd_pc;
    assign rd.rd_inst_o  = r_rd_inst;
    assign level_o       = r_level;
    assign wrapped_o     = r_wrapped;
    assign state_o       = r_state;
endmodule
